// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-stream intake and underflow tracking
// Line/frame order is front porch, sync, back porch, display; all video outputs lag the counters by one cycle.
module vga_timing_gen #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        sof,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_blank,
    output logic [23:0] vid_rgb,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          h_disp;
    logic          v_disp;
    logic          h_sync;
    logic          v_sync;
    logic          disp;
    logic          starve;

    assign h_last = (hcnt == HW'(HTOTAL - 1));
    assign v_last = (vcnt == VW'(VTOTAL - 1));
    assign h_disp = (hcnt >= HW'(HTOTAL - HDISP));
    assign v_disp = (vcnt >= VW'(VTOTAL - VDISP));
    assign h_sync = (hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE));
    assign v_sync = (vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE));
    assign disp   = h_disp && v_disp;
    assign starve = disp && !pix_valid;

    // Counters are already zero in reset, but the gate keeps pix_ready low regardless.
    assign pix_ready = disp && pixel_rst_n;

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hcnt          <= '0;
            vcnt          <= '0;
            vid_hs        <= 1'b1;
            vid_vs        <= 1'b1;
            vid_blank     <= 1'b0;
            vid_rgb       <= '0;
            sof           <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
            vid_hs    <= !h_sync;
            vid_vs    <= !v_sync;
            vid_blank <= disp;
            vid_rgb   <= (disp && pix_valid) ? pix_data : 24'h000000;
            sof       <= (hcnt == '0) && (vcnt == '0);
            // Starvation never stalls the raster; it is only recorded.
            if (starve) begin
                underflow <= 1'b1;
                if (underflow_cnt != 16'hFFFF) begin
                    underflow_cnt <= underflow_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (small-raster and default-raster instances)
module tb_vga_timing_gen;

    localparam int HT    = 64;
    localparam int VT    = 64;
    localparam int FRAME = HT * VT;
    localparam int HS0   = 3;
    localparam int VS0   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] pix_data;
    logic        pix_valid;

    logic        s_ready, s_sof, s_hs, s_vs, s_blank, s_uf;
    logic [23:0] s_rgb;
    logic [15:0] s_ucnt;
    logic        d_ready, d_sof, d_hs, d_vs, d_blank, d_uf;
    logic [23:0] d_rgb;
    logic [15:0] d_ucnt;

    vga_timing_gen #(
        .HDISP(61), .VDISP(61), .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1)
    ) u_small (
        .pixel_clk(clk), .pixel_rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(s_ready), .sof(s_sof), .vid_hs(s_hs), .vid_vs(s_vs),
        .vid_blank(s_blank), .vid_rgb(s_rgb), .underflow(s_uf), .underflow_cnt(s_ucnt)
    );

    vga_timing_gen u_def (
        .pixel_clk(clk), .pixel_rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(d_ready), .sof(d_sof), .vid_hs(d_hs), .vid_vs(d_vs),
        .vid_blank(d_blank), .vid_rgb(d_rgb), .underflow(d_uf), .underflow_cnt(d_ucnt)
    );

    int checks = 0;
    int errors = 0;

    int          cur, n, mode, drop_left;
    logic [23:0] dcount;
    logic        e_uf;
    logic [15:0] e_ucnt;
    int          err_rdy, err_out;
    int          cons_f0, blank_run, max_run, zero_px;
    int          s_sof_cnt, s_sof1, s_sof2;
    int          d_fall1, d_fall2, d_low1, d_vs_low, d_vs_first, d_sof_cnt, d_blank_cnt;
    logic        d_hs_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive inputs at a falling edge, predict, cross the rising edge, compare.
    task automatic step();
        int          h, v;
        logic        rdy, vld, e_hs, e_vs, e_sof;
        logic [23:0] e_rgb;
        h   = cur % HT;
        v   = cur / HT;
        rdy = (h >= HS0) && (v >= VS0);
        case (mode)
            0: vld = rdy ? 1'b1 : 1'($urandom_range(0, 1));
            1: begin
                vld = !(rdy && drop_left > 0);
                if (rdy && drop_left > 0) drop_left--;
            end
            default: vld = 1'b0;
        endcase
        pix_valid = vld;
        pix_data  = dcount;
        if (s_ready !== rdy) err_rdy++;
        if (n < FRAME && s_ready === 1'b1 && vld) cons_f0++;
        e_hs  = (h != 1);
        e_vs  = (v != 1);
        e_sof = (cur == 0);
        e_rgb = (rdy && vld) ? dcount : 24'h000000;
        if (rdy && vld) dcount++;
        if (rdy && !vld) begin
            e_uf = 1'b1;
            if (e_ucnt != 16'hFFFF) e_ucnt++;
        end
        @(negedge clk);
        n++;
        cur = (cur + 1) % FRAME;
        if ({s_hs, s_vs, s_blank, s_rgb, s_sof, s_uf, s_ucnt} !==
            {e_hs, e_vs, rdy, e_rgb, e_sof, e_uf, e_ucnt}) err_out++;
        if (s_blank === 1'b1) begin
            blank_run++;
            if (blank_run > max_run) max_run = blank_run;
            if (s_rgb === 24'h000000) zero_px++;
        end else begin
            blank_run = 0;
        end
        if (s_sof === 1'b1) begin
            s_sof_cnt++;
            if (s_sof_cnt == 1) s_sof1 = n;
            if (s_sof_cnt == 2) s_sof2 = n;
        end
        if (d_hs === 1'b0 && d_hs_prev === 1'b1) begin
            if (d_fall1 == 0) d_fall1 = n;
            else if (d_fall2 == 0) d_fall2 = n;
        end
        if (d_hs === 1'b0 && d_fall2 == 0) d_low1++;
        d_hs_prev = d_hs;
        if (d_vs === 1'b0) begin
            d_vs_low++;
            if (d_vs_first == 0) d_vs_first = n;
        end
        if (d_sof === 1'b1) d_sof_cnt++;
        if (d_blank === 1'b1) d_blank_cnt++;
    endtask

    initial begin
        rst_n = 1'b1; pix_valid = 1'b0; pix_data = 24'h0;
        cur = 0; n = 0; mode = 0; drop_left = 0;
        dcount = 24'h000001; e_uf = 1'b0; e_ucnt = 16'h0;
        err_rdy = 0; err_out = 0; cons_f0 = 0; blank_run = 0; max_run = 0; zero_px = 0;
        s_sof_cnt = 0; s_sof1 = 0; s_sof2 = 0;
        d_fall1 = 0; d_fall2 = 0; d_low1 = 0; d_vs_low = 0; d_vs_first = 0;
        d_sof_cnt = 0; d_blank_cnt = 0; d_hs_prev = 1'b1;

        // Reset values, before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_hs", s_hs, 1);
        check("rst_vs", s_vs, 1);
        check("rst_blank", s_blank, 0);
        check("rst_rgb", s_rgb, 0);
        check("rst_sof", s_sof, 0);
        check("rst_uf", s_uf, 0);
        check("rst_ucnt", s_ucnt, 0);
        check("rst_ready", s_ready, 0);
        check("rst_def_hs", d_hs, 1);
        check("rst_def_vs", d_vs, 1);

        pix_valid = 1'b1;
        pix_data  = 24'hABCDEF;
        repeat (3) @(negedge clk);
        check("rst_hold_ready", s_ready, 0);
        check("rst_hold_def_ready", d_ready, 0);
        check("rst_hold_rgb", s_rgb, 0);
        check("rst_hold_sof", s_sof, 0);

        // Streaming with pix_valid toggling in blanking
        rst_n = 1'b1;
        repeat (14900) step();
        check("a_sof_first", s_sof1, 1);
        check("a_sof_period", s_sof2, 1 + FRAME);
        check("a_sof_count", s_sof_cnt, 4);
        check("a_consumed_frame", cons_f0, 61 * 61);
        check("a_blank_run", max_run, 61);
        check("a_uf", s_uf, 0);
        check("a_ucnt", s_ucnt, 0);
        check("a_def_hs_fall", d_fall1, 41);
        check("a_def_hs_period", d_fall2, 41 + 928);
        check("a_def_hs_width", d_low1, 48);
        check("a_def_vs_first", d_vs_first, 13 * 928 + 1);
        check("a_def_vs_low", d_vs_low, 3 * 928);
        check("a_def_sof_count", d_sof_cnt, 1);
        check("a_def_blank", d_blank_cnt, 0);
        check("a_ready_errs", err_rdy, 0);
        check("a_out_errs", err_out, 0);

        // Five starved display pixels
        mode = 1; drop_left = 5; zero_px = 0;
        repeat (100) step();
        check("b_zero_px", zero_px, 5);
        check("b_uf", s_uf, 1);
        check("b_ucnt", s_ucnt, 5);
        check("b_def_uf", d_uf, 0);
        check("b_ready_errs", err_rdy, 0);
        check("b_out_errs", err_out, 0);

        // Mid-line reset while in display
        mode = 0;
        for (int k = 0; k < FRAME && cur != 45 * HT + 30; k++) step();
        check("c_reach_point", cur, 45 * HT + 30);
        check("c_pre_blank", s_blank, 1);
        rst_n = 1'b0;
        #1;
        check("c_ready", s_ready, 0);
        check("c_hs", s_hs, 1);
        check("c_vs", s_vs, 1);
        check("c_blank", s_blank, 0);
        check("c_rgb", s_rgb, 0);
        check("c_sof", s_sof, 0);
        check("c_uf", s_uf, 0);
        check("c_ucnt", s_ucnt, 0);
        check("c_def_hs", d_hs, 1);
        check("c_def_blank", d_blank, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur = 0; e_uf = 1'b0; e_ucnt = 16'h0;
        step();
        check("c_sof_after_release", s_sof, 1);
        step();
        check("c_sof_one_cycle", s_sof, 0);

        // Starve until the count saturates
        mode = 2;
        for (int k = 0; k < 80000 && e_ucnt != 16'hFFFF; k++) step();
        check("d_sat_reached", e_ucnt, 16'hFFFF);
        repeat (300) step();
        check("d_ucnt_sat", s_ucnt, 16'hFFFF);
        check("d_uf", s_uf, 1);
        check("d_ready_errs", err_rdy, 0);
        check("d_out_errs", err_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter HDISP, 800, active pixels per line.
REQ-002 Parameter VDISP, 480, active lines per frame.
REQ-003 Parameters HFP/HPULSE/HBP, 40/48/40, horizontal front porch, sync pulse and back porch in pixels.
REQ-004 Parameters VFP/VPULSE/VBP, 13/3/29, vertical front porch, sync pulse and back porch in lines.
REQ-005 Port pixel_clk, input, 1, sole clock, all logic on rising edge; one clock; reset is asynchronous and active-low.
REQ-006 Port pixel_rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port pix_data, input, 24, upstream RGB pixel {R,G,B}.
REQ-008 Port pix_valid, input, 1, upstream pixel available.
REQ-009 Port pix_ready, output, 1, pixel consumed this cycle.
REQ-010 Port sof, output, 1, one-cycle start-of-frame pulse to upstream.
REQ-011 Port vid_hs, output, 1, horizontal sync, active low.
REQ-012 Port vid_vs, output, 1, vertical sync, active low.
REQ-013 Port vid_blank, output, 1, 1 = displayed pixel, 0 = blanking.
REQ-014 Port vid_rgb, output, 24, pixel to the video interface.
REQ-015 Port underflow, output, 1, sticky: display pixel needed with pix_valid=0.
REQ-016 Port underflow_cnt, output, 16, count of starved pixels, saturating.

Function
REQ-017 hcnt SHALL count 0..HTOTAL-1 (HTOTAL=HFP+HPULSE+HBP+HDISP=928), wrap to 0; vcnt SHALL increment on hcnt wrap, 0..VTOTAL-1 (VTOTAL=525), wrap to 0.
REQ-018 Line order SHALL be: front porch, sync, back porch, display; hsync region = HFP <= hcnt < HFP+HPULSE; display = hcnt >= HTOTAL-HDISP.
REQ-019 Frame order SHALL be identical on vcnt with VFP/VPULSE/VBP/VDISP.
REQ-020 Display region SHALL be true when both hcnt and vcnt are in their display ranges.
REQ-021 pix_ready SHALL be combinational, equal to display region of current counters; a pixel is consumed when pix_ready & pix_valid.
REQ-022 vid_hs, vid_vs, vid_blank, vid_rgb SHALL be registered, all one cycle after the counters they describe (aligned, latency 1).
REQ-023 vid_rgb SHALL load pix_data when consumed, 24'h000000 when display with pix_valid=0, 24'h000000 in blanking.
REQ-024 Display with pix_valid=0: underflow SHALL set and stay set until reset; underflow_cnt SHALL increment, saturating at 16'hFFFF; counters SHALL NOT stall.
REQ-025 sof SHALL be registered, high for exactly one cycle when hcnt=0 and vcnt=0.
REQ-026 pix_valid in blanking SHALL be ignored (no consumption, no underflow).
REQ-027 Counter widths SHALL be clog2(HTOTAL) and clog2(VTOTAL); no other arithmetic overflow permitted.

Reset
REQ-028 On pixel_rst_n=0, asynchronously: hcnt=0, vcnt=0, vid_hs=1, vid_vs=1, vid_blank=0, vid_rgb=0, sof=0, underflow=0, underflow_cnt=0.
REQ-029 pix_ready SHALL be 0 while pixel_rst_n=0.
REQ-030 Reset mid-frame SHALL abort the frame; after release the first sof occurs on the first cycle (hcnt=0, vcnt=0), next sof exactly 487200 cycles later.

Verification
REQ-031 Release reset, pix_valid=1 -> vid_hs low for 48 cycles starting 41 cycles after release, period 928 cycles; vid_vs low for 3 lines (2784 cycles).
REQ-032 pix_valid=1, pix_data = running counter -> 384000 pixels consumed per frame, vid_rgb equals data one cycle after consumption, vid_blank=1 exactly 800 consecutive cycles per active line.
REQ-033 Drop pix_valid for 5 display cycles -> vid_rgb=0 for those 5 cycles, underflow=1, underflow_cnt=5, timing unchanged.
REQ-034 pix_valid=0 for 1 full frame -> underflow_cnt=16'hFFFF (saturated, not 384000 mod 65536).
REQ-035 Assert pixel_rst_n=0 mid-line at hcnt=500, vcnt=100 -> all outputs at reset values immediately (no clock edge), sof one cycle after release.
REQ-036 pix_valid toggling in blanking -> pix_ready=0, no consumption, underflow stays 0.
